// File: rtl/ibex_vector_load_unit_if.sv
// Data-memory request/response bus between the vector load unit and memory.
// The load unit drives the request side through the master modport.
interface ibex_vector_load_unit_if;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o,
        output data_addr_o,
        output data_we_o,
        output data_be_o,
        input  data_gnt_i,
        input  data_rvalid_i,
        input  data_err_i,
        input  data_rdata_i
    );

    modport slave (
        input  data_req_o,
        input  data_addr_o,
        input  data_we_o,
        input  data_be_o,
        output data_gnt_i,
        output data_rvalid_i,
        output data_err_i,
        output data_rdata_i
    );
endinterface

// File: rtl/ibex_vector_load_unit.sv
// Vector load unit: fetches 1/2/4 consecutive 32-bit words into lanes of a
// 128-bit buffer, then writes them to the vector register file in one cycle.
//
// state | meaning
// IDLE  | waiting for start_i; rejects illegal vlmul / misaligned base
// REQ   | data request held on the bus until granted
// WAIT  | one request outstanding, waiting for rvalid
// WRITE | single-cycle register-file write of the assembled buffer
module ibex_vector_load_unit (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            start_i,
    input  logic [31:0]                     base_addr_i,
    input  logic [4:0]                      vd_i,
    input  logic [2:0]                      vlmul_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    ibex_vector_load_unit_if.master         mem,
    output logic [127:0]                    v_wdata_o,
    output logic [4:0]                      v_waddr_o,
    output logic                            v_we_o,
    output logic                            v_load_en_o,
    output logic [3:0]                      v_wnum_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        WRITE = 2'b11
    } state_t;

    state_t       state;
    logic [127:0] buffer;
    logic [1:0]   word_cnt;
    logic [1:0]   last_cnt;
    logic [1:0]   lane_base;
    logic [31:0]  addr;
    logic         req;

    logic         start_legal;
    logic [1:0]   last_cnt_in;
    logic [1:0]   lane_base_in;
    logic [1:0]   lane;
    logic [127:0] buffer_next;

    // Last word index and first destination lane for each group size.
    always_comb begin
        start_legal  = 1'b0;
        last_cnt_in  = 2'd0;
        lane_base_in = 2'd0;
        case (vlmul_i)
            3'b000: begin
                start_legal  = 1'b1;
                last_cnt_in  = 2'd0;
                lane_base_in = vd_i[1:0];
            end
            3'b001: begin
                start_legal  = 1'b1;
                last_cnt_in  = 2'd1;
                lane_base_in = {vd_i[1], 1'b0};
            end
            3'b010: begin
                start_legal  = 1'b1;
                last_cnt_in  = 2'd3;
                lane_base_in = 2'd0;
            end
            default: begin
                start_legal  = 1'b0;
                last_cnt_in  = 2'd0;
                lane_base_in = 2'd0;
            end
        endcase
        if (base_addr_i[1:0] != 2'b00) begin
            start_legal = 1'b0;
        end
    end

    always_comb begin
        lane        = lane_base + word_cnt;
        buffer_next = buffer;
        buffer_next[{lane, 5'b00000} +: 32] = mem.data_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            buffer      <= '0;
            word_cnt    <= '0;
            last_cnt    <= '0;
            lane_base   <= '0;
            addr        <= '0;
            req         <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            v_we_o      <= 1'b0;
            v_load_en_o <= 1'b0;
            v_wdata_o   <= '0;
            v_waddr_o   <= '0;
        end else begin
            err_o       <= 1'b0;
            done_o      <= 1'b0;
            v_we_o      <= 1'b0;
            v_load_en_o <= 1'b0;
            v_wdata_o   <= '0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (start_legal) begin
                            state     <= REQ;
                            buffer    <= '0;
                            word_cnt  <= '0;
                            last_cnt  <= last_cnt_in;
                            lane_base <= lane_base_in;
                            addr      <= base_addr_i;
                            v_waddr_o <= vd_i;
                            req       <= 1'b1;
                            busy_o    <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.data_gnt_i) begin
                        state <= WAIT;
                        req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem.data_rvalid_i) begin
                        if (mem.data_err_i) begin
                            state  <= IDLE;
                            buffer <= '0;
                            busy_o <= 1'b0;
                            err_o  <= 1'b1;
                        end else if (word_cnt == last_cnt) begin
                            state       <= WRITE;
                            buffer      <= buffer_next;
                            v_wdata_o   <= buffer_next;
                            v_we_o      <= 1'b1;
                            v_load_en_o <= 1'b1;
                            done_o      <= 1'b1;
                        end else begin
                            state    <= REQ;
                            buffer   <= buffer_next;
                            word_cnt <= word_cnt + 2'd1;
                            addr     <= addr + 32'd4;
                            req      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    req    <= 1'b0;
                end
            endcase
        end
    end

    assign mem.data_req_o  = req;
    assign mem.data_addr_o = addr;
    assign mem.data_we_o   = 1'b0;
    assign mem.data_be_o   = 4'b1111;
    assign v_wnum_o        = 4'b0000;

endmodule

// File: tb/tb_ibex_vector_load_unit.sv
// Self-checking bench for ibex_vector_load_unit: a memory responder with
// configurable grant/response delays and a lane-placement reference model.
module tb_ibex_vector_load_unit;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         start_i = 1'b0;
    logic [31:0]  base_addr_i = '0;
    logic [4:0]   vd_i = '0;
    logic [2:0]   vlmul_i = '0;
    logic         busy_o, done_o, err_o;
    logic [127:0] v_wdata_o;
    logic [4:0]   v_waddr_o;
    logic         v_we_o, v_load_en_o;
    logic [3:0]   v_wnum_o;

    ibex_vector_load_unit_if mem_bus ();

    ibex_vector_load_unit dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .vd_i        (vd_i),
        .vlmul_i     (vlmul_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .mem         (mem_bus),
        .v_wdata_o   (v_wdata_o),
        .v_waddr_o   (v_waddr_o),
        .v_we_o      (v_we_o),
        .v_load_en_o (v_load_en_o),
        .v_wnum_o    (v_wnum_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]  mem_words [4];
    logic [31:0]  obs_addrs [$];
    int           obs_write_cyc, obs_err_cyc;
    logic [127:0] obs_wdata;
    logic [4:0]   obs_waddr;
    logic         obs_load_en;
    int           obs_done_cnt, obs_err_cnt, obs_we_cnt, obs_req_cnt;
    int           obs_unstable, obs_spurious;
    bit           obs_timeout;
    logic         obs_busy_end;

    // Reference: word k of the group lands in lane L0+k, all other lanes zero.
    function automatic logic [127:0] model_wdata(input logic [4:0] vd, input logic [2:0] vlmul);
        int n, l0;
        logic [127:0] r;
        n  = 1 << vlmul;
        l0 = (n == 4) ? 0 : (n == 2) ? 2 * int'(vd[1]) : int'(vd % 4);
        r  = '0;
        for (int k = 0; k < n; k++) r = r | (128'(mem_words[k]) << (32 * (l0 + k)));
        return r;
    endfunction

    function automatic int model_cycle(input int n, input int g, input int r);
        return 1 + n * (2 + g + r);
    endfunction

    task automatic clear_mem_inputs();
        mem_bus.data_gnt_i    = 1'b0;
        mem_bus.data_rvalid_i = 1'b0;
        mem_bus.data_err_i    = 1'b0;
        mem_bus.data_rdata_i  = $urandom;
    endtask

    task automatic run_load(input logic [31:0] base, input logic [4:0] vd, input logic [2:0] vlmul,
                            input int gnt_dly, input int rv_dly, input int err_at, input bit poke_start);
        int wait_cnt, rv_cnt, idx;
        bit req_active, pend_rv, finished;
        logic [31:0] hold_addr;
        obs_addrs.delete();
        obs_write_cyc = -1; obs_err_cyc = -1; obs_wdata = '0; obs_waddr = '0; obs_load_en = 1'b0;
        obs_done_cnt = 0; obs_err_cnt = 0; obs_we_cnt = 0; obs_req_cnt = 0;
        obs_unstable = 0; obs_spurious = 0; obs_timeout = 1'b0; obs_busy_end = 1'b0;
        wait_cnt = 0; rv_cnt = 0; idx = 0; req_active = 0; pend_rv = 0; finished = 0; hold_addr = '0;
        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = base; vd_i = vd; vlmul_i = vlmul;
        for (int c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk_i);
            clear_mem_inputs();
            if (mem_bus.data_req_o) obs_req_cnt++;
            if (v_we_o) obs_we_cnt++;
            if (done_o) obs_done_cnt++;
            if (err_o) obs_err_cnt++;
            obs_busy_end = busy_o;
            if (done_o) begin
                obs_write_cyc = c; obs_wdata = v_wdata_o; obs_waddr = v_waddr_o;
                obs_load_en = v_load_en_o; finished = 1;
            end
            if (err_o) begin
                obs_err_cyc = c; finished = 1;
            end
            start_i = 1'b0;
            if (!finished && poke_start && busy_o) begin
                start_i = 1'($urandom_range(0, 1));
                base_addr_i = $urandom; vd_i = 5'($urandom); vlmul_i = 3'($urandom);
            end
            if (!finished) begin
                if (pend_rv) begin
                    if (rv_cnt == rv_dly) begin
                        mem_bus.data_rvalid_i = 1'b1;
                        mem_bus.data_rdata_i  = mem_words[idx];
                        mem_bus.data_err_i    = (idx == err_at);
                        pend_rv = 0; idx++;
                    end else rv_cnt++;
                end else if (mem_bus.data_req_o) begin
                    if (!req_active) begin
                        req_active = 1; hold_addr = mem_bus.data_addr_o; wait_cnt = 0;
                    end else if (mem_bus.data_addr_o !== hold_addr || mem_bus.data_we_o !== 1'b0
                                 || mem_bus.data_be_o !== 4'b1111) obs_unstable++;
                    if (wait_cnt == gnt_dly) begin
                        mem_bus.data_gnt_i = 1'b1;
                        obs_addrs.push_back(mem_bus.data_addr_o);
                        req_active = 0; pend_rv = 1; rv_cnt = 0;
                    end else wait_cnt++;
                end else if (req_active) obs_unstable++;
            end
        end
        if (!finished) obs_timeout = 1'b1;
        start_i = 1'b0;
        clear_mem_inputs();
        repeat (4) begin
            @(negedge clk_i);
            if (busy_o | done_o | err_o | v_we_o | mem_bus.data_req_o) obs_spurious++;
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        clear_mem_inputs();
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({busy_o, done_o, err_o, mem_bus.data_req_o, v_we_o, v_load_en_o, v_wdata_o, mem_bus.data_addr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b req=%b we=%b ld=%b wdata=%h addr=%h required all 0",
                     busy_o, done_o, err_o, mem_bus.data_req_o, v_we_o, v_load_en_o, v_wdata_o, mem_bus.data_addr_o);
        end
        vectors++;
        if ({mem_bus.data_we_o, mem_bus.data_be_o, v_wnum_o} !== {1'b0, 4'b1111, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_constants: got we=%b be=%b wnum=%b required 0/1111/0000",
                     mem_bus.data_we_o, mem_bus.data_be_o, v_wnum_o);
        end
        rstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        logic [127:0] exp_w;
        mem_words[0] = 32'hA5A5A5A5;
        exp_w = model_wdata(5'd6, 3'b000);
        run_load(32'h100, 5'd6, 3'b000, 0, 0, -1, 1'b0);
        vectors++;
        if (obs_timeout !== 1'b0 || obs_addrs.size() != 1) begin
            miscompares++;
            $display("FAIL single_req_count: got %0d requests timeout=%b required 1", obs_addrs.size(), obs_timeout);
        end else begin
            vectors++;
            if (obs_addrs[0] !== 32'h100) begin
                miscompares++;
                $display("FAIL single_addr: got %h required 00000100", obs_addrs[0]);
            end
        end
        vectors++;
        if (obs_write_cyc != 3) begin
            miscompares++;
            $display("FAIL single_latency: got WRITE at t+%0d required t+3", obs_write_cyc);
        end
        vectors++;
        if (obs_wdata !== exp_w || obs_wdata[95:64] !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL single_wdata: got %h required %h", obs_wdata, exp_w);
        end
        vectors++;
        if (obs_waddr !== 5'd6 || obs_load_en !== 1'b1 || obs_done_cnt != 1 || obs_we_cnt != 1) begin
            miscompares++;
            $display("FAIL single_write: got waddr=%0d ld=%b done=%0d we=%0d required 6/1/1/1",
                     obs_waddr, obs_load_en, obs_done_cnt, obs_we_cnt);
        end
    endtask

    task automatic test_quad_delayed_gnt();
        mem_words[0] = 32'h11; mem_words[1] = 32'h22; mem_words[2] = 32'h33; mem_words[3] = 32'h44;
        run_load(32'h200, 5'd8, 3'b010, 2, 0, -1, 1'b0);
        vectors++;
        if (obs_timeout !== 1'b0 || obs_addrs.size() != 4) begin
            miscompares++;
            $display("FAIL quad_req_count: got %0d requests timeout=%b required 4", obs_addrs.size(), obs_timeout);
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (obs_addrs[k] !== 32'h200 + 32'(4 * k)) begin
                    miscompares++;
                    $display("FAIL quad_addr%0d: got %h required %h", k, obs_addrs[k], 32'h200 + 32'(4 * k));
                end
            end
        end
        vectors++;
        if (obs_unstable != 0) begin
            miscompares++;
            $display("FAIL quad_req_stable: got %0d unstable cycles required 0", obs_unstable);
        end
        vectors++;
        if (obs_wdata !== 128'h00000044_00000033_00000022_00000011 || obs_waddr !== 5'd8) begin
            miscompares++;
            $display("FAIL quad_wdata: got %h waddr=%0d required 00000044000000330000002200000011 waddr=8",
                     obs_wdata, obs_waddr);
        end
        vectors++;
        if (obs_write_cyc != model_cycle(4, 2, 0)) begin
            miscompares++;
            $display("FAIL quad_latency: got t+%0d required t+%0d", obs_write_cyc, model_cycle(4, 2, 0));
        end
    endtask

    task automatic test_err_response();
        for (int k = 0; k < 4; k++) mem_words[k] = $urandom;
        run_load(32'h340, 5'd3, 3'b001, 0, 1, 1, 1'b0);
        vectors++;
        if (obs_err_cnt != 1 || obs_we_cnt != 0 || obs_done_cnt != 0 || obs_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL err_resp_pulses: got err=%0d we=%0d done=%0d timeout=%b required 1/0/0/0",
                     obs_err_cnt, obs_we_cnt, obs_done_cnt, obs_timeout);
        end
        vectors++;
        if (obs_busy_end !== 1'b0 || obs_spurious != 0) begin
            miscompares++;
            $display("FAIL err_resp_idle: got busy=%b spurious=%0d required 0/0", obs_busy_end, obs_spurious);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bases [3];
        logic [2:0]  lmuls [3];
        bases[0] = 32'h100; lmuls[0] = 3'b011;
        bases[1] = 32'h102; lmuls[1] = 3'b000;
        bases[2] = 32'h101; lmuls[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            run_load(bases[i], 5'($urandom), lmuls[i], 0, 0, -1, 1'b0);
            vectors++;
            if (obs_err_cnt != 1 || obs_err_cyc != 1 || obs_req_cnt != 0 || obs_busy_end !== 1'b0
                || obs_we_cnt != 0 || obs_spurious != 0) begin
                miscompares++;
                $display("FAIL illegal_%0d: got err=%0d at t+%0d req=%0d busy=%b we=%0d spurious=%0d required 1 at t+1, 0,0,0,0",
                         i, obs_err_cnt, obs_err_cyc, obs_req_cnt, obs_busy_end, obs_we_cnt, obs_spurious);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [127:0] exp_w;
        for (int k = 0; k < 4; k++) mem_words[k] = $urandom;
        exp_w = model_wdata(5'd13, 3'b010);
        run_load(32'h4000, 5'd13, 3'b010, 1, 1, -1, 1'b1);
        vectors++;
        if (obs_addrs.size() != 4 || obs_done_cnt != 1 || obs_err_cnt != 0 || obs_spurious != 0
            || obs_wdata !== exp_w) begin
            miscompares++;
            $display("FAIL busy_start_ignored: got reqs=%0d done=%0d err=%0d spurious=%0d wdata=%h required 4/1/0/0 %h",
                     obs_addrs.size(), obs_done_cnt, obs_err_cnt, obs_spurious, obs_wdata, exp_w);
        end
    endtask

    task automatic test_wrap();
        mem_words[0] = 32'hDEAD0001; mem_words[1] = 32'hBEEF0002;
        run_load(32'hFFFFFFFC, 5'd7, 3'b001, 0, 0, -1, 1'b0);
        vectors++;
        if (obs_addrs.size() != 2 || obs_err_cnt != 0) begin
            miscompares++;
            $display("FAIL wrap_reqs: got %0d requests err=%0d required 2/0", obs_addrs.size(), obs_err_cnt);
        end else begin
            vectors++;
            if (obs_addrs[0] !== 32'hFFFFFFFC || obs_addrs[1] !== 32'h00000000) begin
                miscompares++;
                $display("FAIL wrap_addr: got %h,%h required fffffffc,00000000", obs_addrs[0], obs_addrs[1]);
            end
        end
        vectors++;
        if (obs_wdata !== model_wdata(5'd7, 3'b001)) begin
            miscompares++;
            $display("FAIL wrap_wdata: got %h required %h", obs_wdata, model_wdata(5'd7, 3'b001));
        end
    endtask

    task automatic test_vd0();
        for (int k = 0; k < 4; k++) mem_words[k] = $urandom;
        run_load(32'h80, 5'd0, 3'b000, 0, 0, -1, 1'b0);
        vectors++;
        if (obs_we_cnt != 1 || obs_waddr !== 5'd0 || obs_wdata !== model_wdata(5'd0, 3'b000)) begin
            miscompares++;
            $display("FAIL vd0_write: got we=%0d waddr=%0d wdata=%h required 1/0/%h",
                     obs_we_cnt, obs_waddr, obs_wdata, model_wdata(5'd0, 3'b000));
        end
    endtask

    task automatic test_random();
        logic [31:0] base, tmp;
        logic [4:0]  vd;
        logic [2:0]  lmul;
        int g, r, n;
        bit addr_ok;
        for (int it = 0; it < 24; it++) begin
            tmp  = $urandom;
            base = tmp & 32'hFFFF_FFFC;
            vd   = 5'($urandom);
            lmul = 3'($urandom_range(0, 2));
            g    = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            n    = 1 << lmul;
            for (int k = 0; k < 4; k++) mem_words[k] = $urandom;
            run_load(base, vd, lmul, g, r, -1, 1'b0);
            addr_ok = (obs_addrs.size() == n);
            if (addr_ok) for (int k = 0; k < n; k++) if (obs_addrs[k] !== base + 32'(4 * k)) addr_ok = 0;
            vectors++;
            if (!addr_ok || obs_unstable != 0 || obs_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_addrs: got %0d reqs unstable=%0d timeout=%b required %0d from %h",
                         it, obs_addrs.size(), obs_unstable, obs_timeout, n, base);
            end
            vectors++;
            if (obs_wdata !== model_wdata(vd, lmul) || obs_waddr !== vd || obs_done_cnt != 1) begin
                miscompares++;
                $display("FAIL rand%0d_write: got %h vd=%0d done=%0d required %h vd=%0d done=1",
                         it, obs_wdata, obs_waddr, obs_done_cnt, model_wdata(vd, lmul), vd);
            end
            vectors++;
            if (obs_write_cyc != model_cycle(n, g, r)) begin
                miscompares++;
                $display("FAIL rand%0d_latency: got t+%0d required t+%0d", it, obs_write_cyc, model_cycle(n, g, r));
            end
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = 32'h200; vd_i = 5'd4; vlmul_i = 3'b010;
        @(negedge clk_i);
        start_i = 1'b0;
        mem_bus.data_gnt_i = 1'b1;
        @(negedge clk_i);
        clear_mem_inputs();
        vectors++;
        if (busy_o !== 1'b1 || mem_bus.data_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_in_wait: got busy=%b req=%b required 1/0", busy_o, mem_bus.data_req_o);
        end
        #2 rstn_i = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o, err_o, mem_bus.data_req_o, v_we_o, v_load_en_o, v_wdata_o, mem_bus.data_addr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got busy=%b req=%b addr=%h we=%b required all 0",
                     busy_o, mem_bus.data_req_o, mem_bus.data_addr_o, v_we_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        mem_bus.data_rvalid_i = 1'b1;
        mem_bus.data_rdata_i  = 32'hCAFEF00D;
        spurious = 0;
        repeat (4) begin
            @(negedge clk_i);
            clear_mem_inputs();
            if (busy_o | done_o | err_o | v_we_o | mem_bus.data_req_o) spurious++;
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL reset_mid_late_rvalid: got %0d active cycles required 0", spurious);
        end
        mem_words[0] = 32'h5A5A1234;
        run_load(32'h300, 5'd9, 3'b000, 0, 0, -1, 1'b0);
        vectors++;
        if (obs_done_cnt != 1 || obs_wdata !== model_wdata(5'd9, 3'b000) || obs_write_cyc != 3) begin
            miscompares++;
            $display("FAIL reset_mid_fresh_load: got done=%0d wdata=%h at t+%0d required 1 %h at t+3",
                     obs_done_cnt, obs_wdata, obs_write_cyc, model_wdata(5'd9, 3'b000));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_quad_delayed_gnt();
        test_err_response();
        test_illegal();
        test_busy_start();
        test_wrap();
        test_vd0();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibex_vector_load_unit.md
IBEX_VECTOR_LOAD_UNIT -- requirements
Module: ibex_vector_load_unit

Interface
REQ-001 SHALL have no parameters; widths fixed (32b memory word, 128b register write bus, 4 lanes).
REQ-002 clk_i  input  1  single clock; all state on posedge clk_i.
REQ-003 rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  load request; sampled only in IDLE.
REQ-005 base_addr_i  input  32  byte address of first word.
REQ-006 vd_i  input  5  destination vector register.
REQ-007 vlmul_i  input  3  group multiplier: 000=1 word, 001=2, 010=4, others illegal.
REQ-008 busy_o  output  1  high whenever state != IDLE.
REQ-009 done_o  output  1  one-cycle pulse on successful completion.
REQ-010 err_o  output  1  one-cycle pulse on rejected or aborted load.
REQ-011 data_req_o / data_addr_o[31:0] / data_we_o / data_be_o[3:0]  output  data-memory request; data_we_o=0, data_be_o=4'b1111 constant.
REQ-012 data_gnt_i, data_rvalid_i, data_err_i  input  1 each; data_rdata_i  input  32  memory response.
REQ-013 v_wdata_o  output  128  assembled words to register file write port.
REQ-014 v_waddr_o  output  5  equals captured vd.
REQ-015 v_we_o, v_load_en_o  output  1 each  register-file write strobe and load-mode select.
REQ-016 v_wnum_o  output  4  constant 4'b0000 (unused in load mode).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, WRITE.
REQ-018 IDLE + start_i: capture base_addr_i, vd_i, vlmul_i; clear 128b buffer and word counter; next REQ.
REQ-019 IDLE + start_i with vlmul_i illegal or base_addr_i[1:0]!=0: err_o pulse next cycle, stay IDLE, no memory request.
REQ-020 Word count N: 1/2/4 per vlmul; start lane L0 = vd[1:0] (N=1), {vd[1],0} (N=2), 0 (N=4).
REQ-021 REQ: data_req_o=1, data_addr_o = base + 4*k (k = word counter, mod 2^32); hold all request outputs stable until data_gnt_i; on gnt next WAIT.
REQ-022 At most one outstanding request; data_req_o SHALL be 0 outside REQ.
REQ-023 WAIT: on data_rvalid_i with data_err_i=0, store data_rdata_i into buffer bits [32*(L0+k)+31 : 32*(L0+k)]; if k=N-1 next WRITE, else k+1 and next REQ.
REQ-024 WAIT: on data_rvalid_i with data_err_i=1, discard buffer, err_o pulse next cycle, next IDLE, no register write.
REQ-025 data_rvalid_i outside WAIT SHALL be ignored.
REQ-026 WRITE: one cycle with v_we_o=1, v_load_en_o=1, done_o=1, v_wdata_o=buffer (unused lanes zero); next IDLE.
REQ-027 v_we_o, v_load_en_o, done_o SHALL be 0 in every other state; v_wdata_o SHALL be 0 outside WRITE.
REQ-028 vd=0 SHALL still perform the full load and write cycle (register file suppresses v0 writes).
REQ-029 start_i while busy_o=1 SHALL be ignored, not queued.
REQ-030 Latency with zero-wait memory (gnt same cycle as req, rvalid next cycle): start sampled at cycle t, WRITE at t+1+2N.
REQ-031 Address wrap: 0xFFFFFFFC + 4 SHALL yield 0x00000000, no error.

Reset
REQ-032 rstn_i low SHALL immediately force IDLE, buffer and counter 0, all outputs 0 (busy_o, done_o, err_o, data_req_o, v_we_o, v_load_en_o, v_wdata_o, data_addr_o).
REQ-033 Reset mid-operation SHALL abandon the load without register write; a response arriving after reset release SHALL be ignored (IDLE).

Verification
REQ-034 vlmul=000, vd=6, base=0x100, rdata=0xA5A5A5A5 -> one request at 0x100, WRITE at t+3, v_wdata_o[95:64]=0xA5A5A5A5, other lanes 0, v_waddr_o=6.
REQ-035 vlmul=010, vd=8, base=0x200, rdata 0x11,0x22,0x33,0x44, gnt delayed 2 cycles each -> addresses 0x200/204/208/20C, request held stable, v_wdata_o=0x00000044_00000033_00000022_00000011.
REQ-036 vlmul=001, vd=3, data_err_i=1 on second rvalid -> err_o one pulse, no v_we_o, busy_o low next cycle.
REQ-037 vlmul=011 or base=0x102 -> err_o pulse, data_req_o never asserted; start_i pulses during busy ignored.
REQ-038 rstn_i asserted during WAIT of a 4-word load -> all outputs 0 immediately; late rvalid ignored; fresh 1-word load then completes normally.
